// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one UART TX core between NUM_REQ byte producers.
// Handshake: req is a level sampled only in IDLE; ack[g] and tx_start pulse together when the byte is latched.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       baud_tick,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         done,
    output logic                       timeout_err,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [1:0]                 dbg_state
);
    localparam int GW    = $clog2(NUM_REQ);
    localparam int MAX_T = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
    localparam int CW    = $clog2(MAX_T + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic                 tx_start_q, tx_start_d;
    logic                 active_q, active_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        last_q, last_d;
    logic [CW-1:0]        wdog_q, wdog_d;
    logic [CW-1:0]        gap_q, gap_d;

    logic                 pick_found;
    logic [GW-1:0]        pick_idx;
    logic [GW-1:0]        cand;
    logic                 frame_end;

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        done_d     = '0;
        timeout_d  = 1'b0;
        tx_start_d = 1'b0;
        active_d   = active_q;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        last_d     = last_q;
        wdog_d     = wdog_q;
        gap_d      = gap_q;
        frame_end  = 1'b0;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;

        // Search starts one past the last grant so every pending requester gets a turn.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_q) + k) % NUM_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (pick_found && !tx_busy) begin
                    ack_d[pick_idx] = 1'b1;
                    tx_start_d      = 1'b1;
                    tx_data_d       = req_data[{pick_idx, 3'b000} +: 8];
                    grant_d         = pick_idx;
                    last_d          = pick_idx;
                    active_d        = 1'b1;
                    wdog_d          = '0;
                    state_d         = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    done_d[grant_q] = 1'b1;
                    frame_end       = 1'b1;
                end else if (baud_tick) begin
                    if (wdog_q != CNT_MAX) begin
                        wdog_d = wdog_q + CW'(1);
                    end
                    if (int'(wdog_q) + 1 >= TIMEOUT_TICKS) begin
                        timeout_d = 1'b1;
                        frame_end = 1'b1;
                    end
                end
            end
            GAP: begin
                if (baud_tick) begin
                    if (gap_q <= CW'(1)) begin
                        gap_d    = '0;
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        gap_d = gap_q - CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A zero gap skips GAP entirely so the next grant can follow immediately.
        if (frame_end) begin
            if (GAP_TICKS == 0) begin
                state_d  = IDLE;
                active_d = 1'b0;
            end else begin
                state_d = GAP;
                gap_d   = CW'(GAP_TICKS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            done_q     <= '0;
            timeout_q  <= 1'b0;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_q    <= '0;
            last_q     <= GW'(NUM_REQ - 1);
            wdog_q     <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            tx_start_q <= tx_start_d;
            active_q   <= active_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            wdog_q     <= wdog_d;
            gap_q      <= gap_d;
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign tx_start    = tx_start_q;
    assign active      = active_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign dbg_state   = state_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers. It sits between the requesters and the UART TX core: it selects a requester, latches its byte, and issues a one-cycle start to the transmitter. It then waits for the frame to complete and enforces an inter-frame idle gap, counted in baud ticks from the shared baud generator. A baud-tick watchdog recovers the arbiter if the transmitter never reports completion.

## Interface
- NUM_REQ, 4, number of requesters (2..8).
- GAP_TICKS, 2, idle baud ticks inserted after each frame (0 = no gap).
- TIMEOUT_TICKS, 12, baud ticks allowed between tx_start and tx_done before abort (≥ 11).
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- baud_tick  input  1  one-cycle pulse per bit period from the baud generator.
- req  input  NUM_REQ  per-requester request level; req_data must be valid while high.
- req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- ack  output  NUM_REQ  one-cycle pulse; byte of requester i latched.
- done  output  NUM_REQ  one-cycle pulse; frame of requester i completed.
- timeout_err  output  1  one-cycle pulse; watchdog aborted the current frame.
- grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
- active  output  1  high from grant through end of gap.
- tx_start  output  1  one-cycle start pulse to the UART TX core.
- tx_data  output  8  byte to transmit; stable from tx_start until the next grant.
- tx_busy  input  1  TX core busy; no grant is issued while high.
- tx_done  input  1  one-cycle pulse from the TX core at end of stop bit.

## Operation
- States: IDLE, WAIT_DONE, GAP.
- IDLE: if any req bit is high and tx_busy is low, select the first set bit, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - On selection: latch tx_data, set grant_id, pulse ack[g] and tx_start, set active, update last_grant := g, then go to WAIT_DONE.
- WAIT_DONE: the watchdog counter increments on each baud_tick.
  - tx_done: pulse done[grant_id], then go to GAP, or to IDLE when GAP_TICKS = 0.
  - Watchdog reaches TIMEOUT_TICKS: pulse timeout_err with no done pulse, then go to GAP (or IDLE).
  - tx_done and watchdog expiry in the same cycle: tx_done wins and timeout_err stays low.
- GAP: the gap counter loads GAP_TICKS on entry and decrements on each baud_tick. On reaching 0, clear active and go to IDLE.
- req is sampled only in IDLE. A requester holding req high after ack presents a new byte and competes normally; it is not re-granted ahead of other pending requesters.
- A req dropped before being granted is simply not served; nothing is queued.
- tx_done seen in IDLE or GAP is ignored.
- Counters are sized $clog2(max(GAP_TICKS, TIMEOUT_TICKS)+1) and saturate; they do not wrap.

## Timing
- Reset (rst = 0 at a clk edge) sets:
  - state IDLE;
  - ack, done, timeout_err, tx_start and active to 0;
  - tx_data to 8'h00 and grant_id to 0;
  - last_grant to NUM_REQ-1, so req[0] has first priority after reset;
  - both counters to 0.
- Reset mid-frame returns to IDLE immediately and does not abort the TX core.
- Grant latency: req sampled high in IDLE at edge N produces ack[g], tx_start and tx_data, all registered, at edge N+1.
- Completion: tx_done high at edge M produces done[g] at M+1. The earliest next tx_start is at M+2 when GAP_TICKS = 0.
- With GAP_TICKS = G, the next grant occurs no earlier than 1 cycle after the G-th baud_tick following tx_done.
- ack, done, tx_start and timeout_err are exactly one clk wide; at most one bit of ack and done is high in any cycle.

## Test plan
- Single requester: req[1] high with 8'hAA after reset → ack[1] and tx_start one cycle later, tx_data=8'hAA, grant_id=1; model tx_done → done[1] next cycle, active low after 2 baud ticks.
- All four req high with data 8'h10, 8'h21, 8'h32, 8'h43 held → grants in order 0,1,2,3,0, with one ack per frame and a gap of ≥ 2 baud ticks between tx_start pulses.
- req[3] held continuously, req[1] raised during frame 3 → next grant is 0 (wrap) if pending, else 1; requester 3 is never granted twice while another req is pending.
- tx_done suppressed → timeout_err pulse after 12 baud ticks, no done, arbiter returns to IDLE and serves the next request; tx_done coincident with the 12th tick → done only.
- tx_busy held high with req[2] pending → no ack or tx_start until tx_busy falls, then grant 2 on the next edge.
- rst driven low in WAIT_DONE → next edge all outputs 0 and state IDLE; a subsequent req[2] and req[0] together → grant 0 first.
